// File: rtl/led_pwm_driver.sv
// Six-channel active-low PWM LED driver with frame-aligned double-buffered
// level updates and an optional gradual decay ("comet" fade) on falling levels.
module led_pwm_driver #(
    parameter int PRESCALE    = 1_700,
    parameter int FADE_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] level_in,
    input  logic        load,
    input  logic        fade_en,
    output logic        frame_strobe,
    output logic [5:0]  led
);

    localparam int PW = $clog2(PRESCALE);
    localparam int FW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(FADE_FRAMES - 1);
    localparam logic [3:0]    PHASE_MAX = 4'd14;

    typedef logic [5:0][3:0] levels_t;

    logic [PW-1:0] pre_q,   pre_d;
    logic [3:0]    phase_q, phase_d;
    logic [FW-1:0] fcnt_q,  fcnt_d;
    levels_t       tgt_q,   tgt_d;
    levels_t       act_q,   act_d;
    levels_t       pend_q,  pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [5:0]    led_q,   led_d;
    logic          strobe_q, strobe_d;

    logic    tick;
    logic    boundary;
    logic    decay;
    levels_t new_lvl;

    assign tick     = (pre_q == PRE_MAX);
    assign boundary = tick && (phase_q == PHASE_MAX);
    assign decay    = (fcnt_q == FCNT_MAX);

    // A load on the boundary cycle itself bypasses the pending buffer.
    always_comb begin
        new_lvl = tgt_q;
        if (load) begin
            new_lvl = levels_t'(level_in);
        end else if (pend_valid_q) begin
            new_lvl = pend_q;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        pre_d        = pre_q;
        phase_d      = phase_q;
        fcnt_d       = fcnt_q;
        tgt_d        = tgt_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        strobe_d     = boundary;

        pre_d = tick ? '0 : pre_q + 1'b1;

        if (tick) begin
            phase_d = (phase_q == PHASE_MAX) ? 4'd0 : phase_q + 4'd1;
        end

        if (boundary) begin
            tgt_d        = new_lvl;
            pend_valid_d = 1'b0;
            fcnt_d       = decay ? '0 : fcnt_q + 1'b1;
            // A falling level drops one step only on decay frames; since new < act there,
            // act-1 can neither underflow nor undershoot the target.
            for (int i = 0; i < 6; i++) begin
                if (!fade_en || (new_lvl[i] >= act_q[i])) begin
                    act_d[i] = new_lvl[i];
                end else if (decay) begin
                    act_d[i] = act_q[i] - 4'd1;
                end
            end
        end else if (load) begin
            pend_d       = levels_t'(level_in);
            pend_valid_d = 1'b1;
        end

        for (int i = 0; i < 6; i++) begin
            led_d[i] = ~(phase_q < act_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the level arrays are plain flops, not RAM, so they are reset like everything else.
        if (reset) begin
            pre_q        <= '0;
            phase_q      <= 4'd0;
            fcnt_q       <= '0;
            tgt_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            led_q        <= 6'b111111;
            strobe_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            pre_q        <= pre_d;
            phase_q      <= phase_d;
            fcnt_q       <= fcnt_d;
            tgt_q        <= tgt_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            led_q        <= led_d;
            strobe_q     <= strobe_d;
        end
    end

    assign led          = led_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench: dut_a (PRESCALE=4, 60-cycle frames) covers update timing and PWM
// shape; dut_b (PRESCALE=2, FADE_FRAMES=2, 30-cycle frames) covers fade and reset.
module tb_led_pwm_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] level_a = '0, level_b = '0;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic        fade_a = 1'b0, fade_b = 1'b0;
    logic        strobe_a, strobe_b;
    logic [5:0]  led_a, led_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    led_pwm_driver #(.PRESCALE(4), .FADE_FRAMES(16)) dut_a (
        .clk(clk), .reset(reset), .level_in(level_a), .load(load_a),
        .fade_en(fade_a), .frame_strobe(strobe_a), .led(led_a)
    );

    led_pwm_driver #(.PRESCALE(2), .FADE_FRAMES(2)) dut_b (
        .clk(clk), .reset(reset), .level_in(level_b), .load(load_b),
        .fade_en(fade_b), .frame_strobe(strobe_b), .led(led_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After return the bench sits in cycle 0: first cycle with reset low.
    task automatic do_reset();
        reset  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (led_a !== 6'b111111 || strobe_a !== 1'b0 || led_b !== 6'b111111) begin
                errors++;
                $display("FAIL reset_hold k=%0d led_a=%b strobe_a=%b led_b=%b exp 111111/0/111111",
                         k, led_a, strobe_a, led_b);
            end
        end
        reset = 1'b0;
        cyc   = 0;
        while (cyc <= 200) begin
            checks++;
            if (led_a !== 6'b111111 || led_b !== 6'b111111) begin
                errors++;
                $display("FAIL idle_led cyc=%0d led_a=%b led_b=%b exp 111111", cyc, led_a, led_b);
            end
            checks++;
            if (strobe_a !== (cyc > 0 && cyc % 60 == 0) || strobe_b !== (cyc > 0 && cyc % 30 == 0)) begin
                errors++;
                $display("FAIL idle_strobe cyc=%0d strobe_a=%b strobe_b=%b exp %b/%b", cyc, strobe_a,
                         strobe_b, (cyc > 0 && cyc % 60 == 0), (cyc > 0 && cyc % 30 == 0));
            end
            step();
        end
    endtask

    task automatic test_full_on();
        logic [5:0] exp;
        do_reset();
        while (cyc <= 240) begin
            exp = (cyc <= 60) ? 6'b111111 : 6'b111110;
            checks++;
            if (led_a !== exp) begin
                errors++;
                $display("FAIL full_on cyc=%0d led=%b exp=%b", cyc, led_a, exp);
            end
            load_a  = (cyc == 3);
            level_a = 24'h00000F;
            step();
        end
        load_a = 1'b0;
    endtask

    // Level 5 lights the frame's first 5 ticks (20 cycles), visible one cycle late.
    task automatic test_partial();
        logic [5:0] exp;
        do_reset();
        while (cyc <= 240) begin
            exp = (cyc >= 61 && ((cyc - 1) % 60) / 4 < 5) ? 6'b111011 : 6'b111111;
            checks++;
            if (led_a !== exp) begin
                errors++;
                $display("FAIL partial cyc=%0d led=%b exp=%b", cyc, led_a, exp);
            end
            load_a  = (cyc == 3);
            level_a = 24'h000500;
            step();
        end
        load_a = 1'b0;
    endtask

    // Two loads in frame 0 (last wins), then a load exactly on the boundary at cycle 119.
    task automatic test_back_to_back();
        logic [5:0] exp;
        do_reset();
        while (cyc <= 200) begin
            exp = (cyc <= 60) ? 6'b111111 : (cyc <= 120) ? 6'b111101 : 6'b110111;
            checks++;
            if (led_a !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d led=%b exp=%b", cyc, led_a, exp);
            end
            load_a  = (cyc == 3 || cyc == 10 || cyc == 119);
            level_a = (cyc == 3) ? 24'h00000F : (cyc == 10) ? 24'h0000F0 : 24'h00F000;
            step();
        end
        load_a = 1'b0;
    endtask

    // Frame m spans led cycles [30m+1, 30m+30]; lit cycles = 2 * displayed level.
    task automatic test_fade();
        int lit, other, m, exp_a;
        do_reset();
        fade_b = 1'b1;
        lit    = 0;
        other  = 0;
        while (cyc <= 30 * 39) begin
            if (cyc > 0) begin
                if (led_b[1] === 1'b0) lit++;
                if ({led_b[5:2], led_b[0]} !== 5'b11111) other++;
                if (cyc % 30 == 0) begin
                    m = (cyc - 1) / 30;
                    if (m == 0) exp_a = 0;
                    else if (m <= 3) exp_a = 15;
                    else if (m == 37) exp_a = 15;
                    else if (m >= 38) exp_a = 0;
                    else exp_a = (15 - (m - 2) / 2 < 0) ? 0 : 15 - (m - 2) / 2;
                    checks++;
                    if (lit !== 2 * exp_a || other !== 0) begin
                        errors++;
                        $display("FAIL fade frame=%0d lit=%0d exp=%0d other_lit=%0d exp=0",
                                 m, lit, 2 * exp_a, other);
                    end
                    lit   = 0;
                    other = 0;
                end
            end
            load_b  = (cyc == 3 || cyc == 65 || cyc == 1085 || cyc == 1115);
            level_b = (cyc == 3 || cyc == 1085) ? 24'h0000F0 : 24'h000000;
            if (cyc == 1115) fade_b = 1'b0;
            step();
        end
        load_b = 1'b0;
        fade_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fade_b = 1'b1;
        while (cyc <= 80) begin
            load_b  = (cyc == 3 || cyc == 75);
            level_b = (cyc == 3) ? 24'h0000F0 : 24'h00000F;
            if (cyc == 80) reset = 1'b1;
            step();
        end
        load_b = 1'b0;
        checks++;
        if (led_b !== 6'b111111 || strobe_b !== 1'b0 || led_a !== 6'b111111) begin
            errors++;
            $display("FAIL reset_mid cyc=%0d led_b=%b strobe_b=%b led_a=%b exp 111111/0/111111",
                     cyc, led_b, strobe_b, led_a);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        fade_b = 1'b0;
        cyc    = 0;
        while (cyc <= 100) begin
            checks++;
            if (led_b !== 6'b111111 || strobe_b !== (cyc > 0 && cyc % 30 == 0)) begin
                errors++;
                $display("FAIL after_reset cyc=%0d led_b=%b strobe_b=%b exp 111111/%b",
                         cyc, led_b, strobe_b, (cyc > 0 && cyc % 30 == 0));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_full_on();
        test_partial();
        test_back_to_back();
        test_fade();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
